// File: rtl/seq_gates_nl0_pkg.sv
// Shared constants for the seq_gates_nl0 netlist primitive.
// Holds the common flop reset value used by every state element.
package seq_gates_nl0_pkg;

  localparam logic RST_VAL = 1'b0;

endpackage

// File: rtl/seq_gates_nl0_dff_ar.sv
// 1-bit D flip-flop with asynchronous active-high reset to RST_VAL.
// Used as the storage leaf of the seq_gates_nl0 netlist.
module dff_ar
  import seq_gates_nl0_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/seq_gates_nl0.sv
// Two registered inputs feeding a 2-input AND gate: out is the AND of the
// inputs captured at the previous rising edge; reset clears both flops at once.
module seq_gates_nl0
  import seq_gates_nl0_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in0,
  input  logic in1,
  output logic out
);

  logic q0_q;
  logic q1_q;

  dff_ar u_q0 (
    .clk   (clk),
    .reset (reset),
    .d     (in0),
    .q     (q0_q)
  );

  dff_ar u_q1 (
    .clk   (clk),
    .reset (reset),
    .d     (in1),
    .q     (q1_q)
  );

  // Output depends only on flop state, never directly on in0/in1.
  assign out = q0_q & q1_q;

endmodule

// File: tb/tb_seq_gates_nl0.sv
// Directed and short random checks for seq_gates_nl0: one-cycle latency,
// asynchronous reset, and absence of any input-to-output combinational path.
module tb_seq_gates_nl0;

  logic clk;
  logic reset;
  logic in0;
  logic in1;
  logic out;

  int checks;
  int errors;
  logic prev_a;
  logic prev_b;
  logic ra;
  logic rb;

  seq_gates_nl0 dut (
    .clk   (clk),
    .reset (reset),
    .in0   (in0),
    .in1   (in1),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: out=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: out=%b at t=%0t", tag, obs, $time);
    end
  endtask

  // Drive (a,b) 1 unit after the edge, check out just before the next edge.
  task automatic step(input logic a, input logic b, input logic exp, input string tag);
    @(posedge clk);
    #1;
    in0 = a;
    in1 = b;
    #7;
    chk(tag, out, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    in0    = 1'b1;
    in1    = 1'b1;

    // Reset clears the flops before any clock edge has occurred.
    #1;
    chk("rst_no_edge", out, 1'b0);
    in0 = 1'b0;
    in1 = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_held", out, 1'b0);
    reset = 1'b0;

    // 1. Hold (0,0) for two cycles.
    step(1'b0, 1'b0, 1'b0, "t1_c0");
    step(1'b0, 1'b0, 1'b0, "t1_c1");

    // 2. Directed truth-table sequence.
    step(1'b0, 1'b0, 1'b0, "t2_00");
    step(1'b0, 1'b1, 1'b0, "t2_01");
    step(1'b1, 1'b0, 1'b0, "t2_10");
    step(1'b1, 1'b1, 1'b0, "t2_11");
    step(1'b0, 1'b0, 1'b1, "t2_after11");

    // 3. Hold (1,1) for three cycles, then (0,1), then (0,0).
    step(1'b1, 1'b1, 1'b0, "t3_h0");
    step(1'b1, 1'b1, 1'b1, "t3_h1");
    step(1'b1, 1'b1, 1'b1, "t3_h2");
    step(1'b0, 1'b1, 1'b1, "t3_01");
    step(1'b0, 1'b0, 1'b0, "t3_fall");

    // 4. Asynchronous reset while out is high.
    step(1'b1, 1'b1, 1'b0, "t4_load");
    @(posedge clk);
    #1;
    chk("t4_high", out, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("t4_async", out, 1'b0);
    @(posedge clk);
    #1;
    chk("t4_hold", out, 1'b0);
    #1;
    reset = 1'b0;
    #5;
    chk("t4_post_c0", out, 1'b0);
    step(1'b0, 1'b0, 1'b1, "t4_post_c1");
    step(1'b0, 1'b0, 1'b0, "t4_post_c2");

    // 5. Glitch inputs between edges, restoring (0,0) before each edge.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      in0 = 1'b0;
      in1 = 1'b0;
      #2;
      in0 = 1'b1;
      in1 = 1'b1;
      #1;
      chk("t5_mid", out, 1'b0);
      #2;
      in0 = 1'b0;
      in1 = 1'b0;
      #2;
      chk("t5_end", out, 1'b0);
    end

    // 6. Short reset pulse, then 20 random cycles against a one-cycle model.
    @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    prev_a = 1'b0;
    prev_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      step(ra, rb, prev_a & prev_b, $sformatf("t6_rnd%0d", i));
      prev_a = ra;
      prev_b = rb;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
